// File: rtl/game_pkg.sv
// Shared types and helpers for the maze round sequencer.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PLAY    = 3'd1,
    RESPAWN = 3'd2,
    OVER    = 3'd3,
    WIN     = 3'd4
  } game_state_t;

  typedef logic [11:0] bcd3_t;

  localparam bcd3_t BCD_MAX = 12'h999;

  // Elaboration-time binary to 3-digit BCD, clamped at 999.
  function automatic bcd3_t to_bcd3(input int unsigned v);
    int unsigned c;
    c = (v > 999) ? 999 : v;
    return {4'(c / 100), 4'((c / 10) % 10), 4'(c % 10)};
  endfunction

endpackage

// File: rtl/game_sequencer_bcd.sv
// Three-digit BCD up-counter with synchronous clear, saturating at 999.
module bcd_counter3
  import game_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  clear,
  input  logic  inc,
  output bcd3_t q
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      q <= '0;
    end else if (inc && (q != BCD_MAX)) begin
      if (q[3:0] != 4'd9) begin
        q[3:0] <= q[3:0] + 4'd1;
      end else begin
        q[3:0] <= '0;
        // Hundreds cannot be 9 here because q != 999 with the low digits at 99.
        if (q[7:4] != 4'd9) begin
          q[7:4] <= q[7:4] + 4'd1;
        end else begin
          q[7:4]  <= '0;
          q[11:8] <= q[11:8] + 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/game_sequencer.sv
// Round sequencer: idle, play, lava respawn, game over and win, with lives and BCD timer.
module game_sequencer
  import game_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter int unsigned LIVES        = 3,
  parameter int unsigned RESPAWN_CYC  = 25_000_000,
  parameter int unsigned TIME_LIMIT_S = 999
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_button,
  input  logic        lavablks,
  input  logic        goalblk,
  output logic        gamestart,
  output logic        freeze,
  output logic        gameover,
  output logic        complete,
  output logic [1:0]  lives,
  output logic [11:0] secs_bcd,
  output logic [2:0]  state
);

  localparam int unsigned PRE_W = $clog2(CLK_HZ + 1);
  localparam int unsigned RSP_W = $clog2(RESPAWN_CYC + 1);
  localparam bcd3_t LIMIT_M1 = to_bcd3(TIME_LIMIT_S - 1);

  game_state_t      r_state;
  game_state_t      w_nxt;
  logic [1:0]       r_lives;
  logic [1:0]       w_lives_nxt;
  logic [PRE_W-1:0] r_pre;
  logic [RSP_W-1:0] r_resp;
  logic             w_running;
  logic             w_tick;
  logic             w_hit;
  logic             w_restart;
  logic             w_resp_clr;
  bcd3_t            w_secs;

  assign w_running = (r_state == PLAY) || (r_state == RESPAWN);
  assign w_tick    = w_running && (r_pre == PRE_W'(CLK_HZ - 1));
  // Limit fires on the increment that lands on TIME_LIMIT_S, so compare against limit-1.
  assign w_hit     = w_tick && (w_secs == LIMIT_M1);

  always_comb begin
    w_nxt       = r_state;
    w_lives_nxt = r_lives;
    w_restart   = 1'b0;
    w_resp_clr  = 1'b0;
    case (r_state)
      IDLE, OVER, WIN: begin
        if (start_button) begin
          w_nxt       = PLAY;
          w_lives_nxt = 2'(LIVES);
          w_restart   = 1'b1;
        end
      end
      PLAY: begin
        if (goalblk) begin
          w_nxt = WIN;
        end else if (lavablks) begin
          if (r_lives > 2'd1) begin
            w_nxt       = RESPAWN;
            w_lives_nxt = r_lives - 2'd1;
            w_resp_clr  = 1'b1;
          end else begin
            w_nxt       = OVER;
            w_lives_nxt = '0;
          end
        end else if (w_hit) begin
          w_nxt = OVER;
        end
      end
      RESPAWN: begin
        if (w_hit) begin
          w_nxt = OVER;
        end else if (r_resp == RSP_W'(RESPAWN_CYC - 1)) begin
          w_nxt = PLAY;
        end
      end
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_lives   <= '0;
      r_pre     <= '0;
      r_resp    <= '0;
      gamestart <= 1'b1;
      freeze    <= 1'b1;
      gameover  <= 1'b0;
      complete  <= 1'b0;
    end else begin
      r_state   <= w_nxt;
      r_lives   <= w_lives_nxt;
      gamestart <= (w_nxt == IDLE) || (w_nxt == RESPAWN);
      freeze    <= (w_nxt != PLAY);
      gameover  <= (w_nxt == OVER);
      complete  <= (w_nxt == WIN);
      if (w_restart || w_tick) begin
        r_pre <= '0;
      end else if (w_running) begin
        r_pre <= r_pre + 1'b1;
      end
      if (w_resp_clr) begin
        r_resp <= '0;
      end else if (r_state == RESPAWN) begin
        r_resp <= r_resp + 1'b1;
      end
    end
  end

  bcd_counter3 u_timer (
    .clk   (clk),
    .reset (reset),
    .clear (w_restart),
    .inc   (w_tick),
    .q     (w_secs)
  );

  assign secs_bcd = w_secs;
  assign lives    = r_lives;
  assign state    = r_state;

endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer: directed table, random vs reference model, saturation.
module tb_game_sequencer;

  localparam int unsigned CLK_HZ = 10;
  localparam int unsigned LIVES  = 3;
  localparam int unsigned RESP   = 4;
  localparam int unsigned LIMIT  = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1, start_button = 1'b0, lavablks = 1'b0, goalblk = 1'b0;
  logic        gamestart, freeze, gameover, complete;
  logic [1:0]  lives;
  logic [11:0] secs_bcd;
  logic [2:0]  state;

  game_sequencer #(.CLK_HZ(CLK_HZ), .LIVES(LIVES), .RESPAWN_CYC(RESP), .TIME_LIMIT_S(LIMIT)) dut (
    .clk(clk), .reset(reset), .start_button(start_button), .lavablks(lavablks), .goalblk(goalblk),
    .gamestart(gamestart), .freeze(freeze), .gameover(gameover), .complete(complete),
    .lives(lives), .secs_bcd(secs_bcd), .state(state)
  );

  logic        s_reset = 1'b1, s_start = 1'b0, s_lava = 1'b0, s_goal = 1'b0;
  logic        s_gs, s_fr, s_go, s_cp;
  logic [1:0]  s_lives;
  logic [11:0] s_secs;
  logic [2:0]  s_state;

  game_sequencer #(.CLK_HZ(CLK_HZ), .LIVES(LIVES), .RESPAWN_CYC(RESP), .TIME_LIMIT_S(999)) u_sat (
    .clk(clk), .reset(s_reset), .start_button(s_start), .lavablks(s_lava), .goalblk(s_goal),
    .gamestart(s_gs), .freeze(s_fr), .gameover(s_go), .complete(s_cp),
    .lives(s_lives), .secs_bcd(s_secs), .state(s_state)
  );

  logic        b_rst = 1'b1, b_clear = 1'b0, b_inc = 1'b0;
  logic [11:0] b_q;

  bcd_counter3 u_bcd (.clk(clk), .reset(b_rst), .clear(b_clear), .inc(b_inc), .q(b_q));

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  function automatic logic [11:0] dec2bcd(input int unsigned v);
    int unsigned c;
    c = (v > 999) ? 999 : v;
    return {4'(c / 100), 4'((c / 10) % 10), 4'(c % 10)};
  endfunction

  // {state, gamestart, freeze, gameover, complete, lives, secs_bcd}
  function automatic logic [20:0] pack_exp(input int st, input int lv, input int unsigned sec);
    logic gs, fr, go, cp;
    gs = (st == 0) || (st == 2);
    fr = (st != 1);
    go = (st == 3);
    cp = (st == 4);
    return {3'(st), gs, fr, go, cp, 2'(lv), dec2bcd(sec)};
  endfunction

  task automatic check(input string name, input logic [20:0] act, input logic [20:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got st=%0d gs/fr/go/cp=%b lives=%0d secs=%h, expected st=%0d gs/fr/go/cp=%b lives=%0d secs=%h",
               name, act[20:18], act[17:14], act[13:12], act[11:0],
               exp[20:18], exp[17:14], exp[13:12], exp[11:0]);
    end
  endtask

  function automatic logic [20:0] dut_out();
    return {state, gamestart, freeze, gameover, complete, lives, secs_bcd};
  endfunction

  typedef struct {
    bit st; bit lv; bit gl; bit rs;
    int n;
    int e_state; int e_lives; int e_secs;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit st, lv, gl, rs, input int n, es, el, esec);
    vec_t v;
    v.st = st; v.lv = lv; v.gl = gl; v.rs = rs; v.n = n;
    v.e_state = es; v.e_lives = el; v.e_secs = esec;
    tbl.push_back(v);
  endtask

  // Reference model: elapsed running cycles since round start define the timer.
  int m_st, m_lives, m_left;
  int unsigned m_run;

  task automatic model_edge(input bit s, l, g, r);
    bit hit;
    if (r) begin
      m_st = 0; m_lives = 0; m_run = 0; m_left = 0;
    end else begin
      case (m_st)
        0, 3, 4: if (s) begin m_st = 1; m_lives = LIVES; m_run = 0; end
        1: begin
          m_run = m_run + 1;
          hit = (m_run % CLK_HZ == 0) && (m_run / CLK_HZ == LIMIT);
          if (g) m_st = 4;
          else if (l) begin
            if (m_lives > 1) begin m_lives = m_lives - 1; m_st = 2; m_left = RESP; end
            else begin m_lives = 0; m_st = 3; end
          end else if (hit) m_st = 3;
        end
        2: begin
          m_run = m_run + 1;
          hit = (m_run % CLK_HZ == 0) && (m_run / CLK_HZ == LIMIT);
          if (hit) m_st = 3;
          else begin
            m_left = m_left - 1;
            if (m_left == 0) m_st = 1;
          end
        end
        default: m_st = 0;
      endcase
    end
  endtask

  initial begin
    // start lava goal rst  n   state lives secs
    add(0, 0, 0, 1,   3,  0, 0,  0);
    add(0, 0, 0, 0,   1,  0, 0,  0);
    add(1, 0, 0, 0,   1,  1, 3,  0);
    add(0, 0, 0, 0,  95,  1, 3,  9);
    add(0, 0, 0, 0,  10,  1, 3, 10);
    add(0, 1, 0, 0,   1,  2, 2, 10);
    add(0, 0, 0, 0,   3,  2, 2, 10);
    add(0, 0, 0, 0,   1,  1, 2, 11);
    add(0, 1, 0, 0,   1,  2, 1, 11);
    add(0, 0, 0, 0,   4,  1, 1, 11);
    add(0, 1, 0, 0,   1,  3, 0, 11);
    add(0, 0, 0, 0,  20,  3, 0, 11);
    add(1, 0, 0, 0,   1,  1, 3,  0);
    add(0, 1, 1, 0,   1,  4, 3,  0);
    add(0, 0, 0, 0,   5,  4, 3,  0);
    add(1, 0, 0, 0,   1,  1, 3,  0);
    add(1, 0, 0, 0, 119,  1, 3, 11);
    add(0, 0, 0, 0,   1,  3, 3, 12);
    add(0, 0, 0, 0,  15,  3, 3, 12);
    add(1, 0, 0, 0,   1,  1, 3,  0);
    add(0, 1, 0, 0,   1,  2, 2,  0);
    add(0, 0, 0, 0,   2,  2, 2,  0);
    add(0, 0, 0, 1,   1,  0, 0,  0);
    add(0, 0, 0, 0,   1,  0, 0,  0);
    add(1, 1, 0, 0,   1,  1, 3,  0);
    add(0, 1, 0, 0,   1,  2, 2,  0);
    add(0, 0, 1, 0,   4,  1, 2,  0);
    add(0, 0, 0, 0,   1,  1, 2,  0);
    add(0, 0, 1, 0,   1,  4, 2,  0);

    @(negedge clk);
    foreach (tbl[i]) begin
      start_button = tbl[i].st; lavablks = tbl[i].lv; goalblk = tbl[i].gl; reset = tbl[i].rs;
      repeat (tbl[i].n) @(posedge clk);
      @(negedge clk);
      check($sformatf("tbl%0d", i), dut_out(), pack_exp(tbl[i].e_state, tbl[i].e_lives, tbl[i].e_secs));
    end

    for (int i = 0; i < 3000; i++) begin
      start_button = ($urandom_range(0, 19) == 0);
      lavablks     = ($urandom_range(0, 24) == 0);
      goalblk      = ($urandom_range(0, 59) == 0);
      reset        = (i < 2) || ($urandom_range(0, 399) == 0);
      @(posedge clk);
      model_edge(start_button, lavablks, goalblk, reset);
      @(negedge clk);
      check($sformatf("rand%0d", i), dut_out(), pack_exp(m_st, m_lives, m_run / CLK_HZ));
    end
    start_button = 1'b0; lavablks = 1'b0; goalblk = 1'b0; reset = 1'b0;

    s_reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    s_reset = 1'b0; s_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_start = 1'b0;
    repeat (9989) @(posedge clk);
    @(negedge clk);
    check("sat_998", {s_state, s_gs, s_fr, s_go, s_cp, s_lives, s_secs}, pack_exp(1, 3, 998));
    @(posedge clk);
    @(negedge clk);
    check("sat_999_over", {s_state, s_gs, s_fr, s_go, s_cp, s_lives, s_secs}, pack_exp(3, 3, 999));
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("sat_hold", {s_state, s_gs, s_fr, s_go, s_cp, s_lives, s_secs}, pack_exp(3, 3, 999));

    b_rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bcd_reset", {9'd0, b_q}, {9'd0, 12'h000});
    b_rst = 1'b0; b_inc = 1'b1;
    for (int n = 1; n <= 1005; n++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("bcd_inc%0d", n), {9'd0, b_q}, {9'd0, dec2bcd(n)});
    end
    b_clear = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bcd_clear", {9'd0, b_q}, {9'd0, 12'h000});
    b_clear = 1'b0; b_inc = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
Central FSM that sequences a maze round: idle/attract, play, respawn after lava, game over, and win. It owns the lives count, a BCD elapsed-seconds timer, and the player-block hold/reset (`gamestart`). It replaces the ad-hoc start/end logic feeding the player block, the HEX display driver and the colour mux. It consumes the interaction flags from the block-interaction logic and debounced single-pulse buttons.

Parameters:
CLK_HZ, 50_000_000, clk cycles per elapsed second
LIVES, 3, lives granted at round start (1..3)
RESPAWN_CYC, 25_000_000, cycles player is held at start after a lava death
TIME_LIMIT_S, 999, round ends as game over when timer reaches this value (1..999)

Ports:
clk  in  1  system clock (CLOCK_50 at top level)
reset  in  1  synchronous, active-high
start_button  in  1  one-cycle pulse, debounced start press
lavablks  in  1  level: player overlaps a lava pit
goalblk  in  1  level: player overlaps the finish line
gamestart  out  1  hold player at start position (drives player reset)
freeze  out  1  ignore movement inputs
gameover  out  1  round lost
complete  out  1  round won
lives  out  2  remaining lives
secs_bcd  out  12  elapsed seconds, 3 BCD digits, [11:8] hundreds
state  out  3  current state encoding, for HEX/debug

Behaviour:
- Clocking: one clock, clk. Reset is synchronous and active-high. All outputs are registered and reflect inputs sampled on the previous edge (1-cycle latency).
- Reset values: state=IDLE, gamestart=1, freeze=1, gameover=0, complete=0, lives=0, secs_bcd=0, prescaler=0, respawn counter=0.
- IDLE: gamestart=1, freeze=1.
  - start_button -> PLAY.
  - On that edge: lives<=LIVES, secs_bcd<=0, prescaler<=0.
- PLAY: gamestart=0, freeze=0. Prescaler counts 0..CLK_HZ-1; on wrap, secs_bcd increments by one.
  - Priority (highest first): goalblk -> WIN; lavablks -> RESPAWN or OVER; timer reaching TIME_LIMIT_S -> OVER.
  - goalblk: -> WIN. Timer freezes at its current value.
  - lavablks with lives>1: -> RESPAWN, lives<=lives-1, respawn counter<=0.
  - lavablks with lives==1: -> OVER, lives<=0.
  - Timer: on the increment that makes secs_bcd equal TIME_LIMIT_S -> OVER. lives unchanged.
  - start_button is ignored in PLAY.
- RESPAWN: gamestart=1, freeze=1.
  - Timer keeps running; this is the death penalty.
  - Counter runs 0..RESPAWN_CYC-1, then -> PLAY on the next edge.
  - lavablks and goalblk are ignored here: the player is forced to start, so the flags clear.
  - Timer limit reached during RESPAWN -> OVER immediately.
- OVER: gameover=1, freeze=1, gamestart=0. The player stays visible where it died; the timer holds.
- WIN: complete=1, freeze=1, gamestart=0; the timer holds.
- OVER/WIN exit: start_button -> PLAY with full reinit (same as from IDLE). gameover and complete clear on that edge.
- lavablks and goalblk are sampled only in PLAY. A level held across the PLAY entry edge triggers on the first PLAY cycle.
- BCD arithmetic:
  - Each digit wraps 9->0 with carry into the next.
  - 999 saturates (no wrap) even if TIME_LIMIT_S is unreachable.
  - Digits never hold values above 9.
- Reset mid-operation (any state): the next edge returns to IDLE with reset values. No pulses are emitted.
- One-hot outputs: gameover and complete are never both 1. gamestart and freeze are 1 together only in IDLE/RESPAWN.

Decomposition:
- Shared package game_pkg:
  - typedef enum logic [2:0] game_state_t {IDLE=0, PLAY=1, RESPAWN=2, OVER=3, WIN=4}
  - typedef logic [11:0] bcd3_t
  - constant BCD_MAX = 12'h999
- Sub-module bcd_counter3:
  - Inputs: clk, reset, clear, inc.
  - Outputs: q (bcd3_t), saturating at 999.
  - Instantiated once for the timer.
- Prescaler, respawn counter and FSM stay in game_sequencer.

Test Plan (sim params CLK_HZ=10, LIVES=3, RESPAWN_CYC=4, TIME_LIMIT_S=12):
1. Reset 3 cycles, then release -> state=IDLE, gamestart=1, freeze=1, lives=0, secs_bcd=0x000. A start_button pulse -> next cycle state=PLAY, lives=3, gamestart=0.
2. PLAY for 95 cycles -> secs_bcd=0x009. Run 10 more -> secs_bcd=0x010, confirming the BCD carry.
3. In PLAY, pulse lavablks for 1 cycle -> RESPAWN, lives=2, gamestart=1 for exactly 4 cycles, then PLAY. Repeat twice -> the third lava hit gives OVER, lives=0, gameover=1, and secs_bcd holds.
4. lavablks and goalblk asserted in the same PLAY cycle -> WIN, complete=1, lives unchanged. A start_button pulse -> PLAY, lives=3, secs_bcd=0x000, complete=0.
5. No events for 120 PLAY cycles -> secs_bcd=0x012 and the state goes to OVER on the same edge. A start_button pulse held through PLAY -> no effect.
6. Assert reset mid-RESPAWN (counter=2) -> next edge IDLE, all outputs at reset values. Separately, with TIME_LIMIT_S=999, force 1000 s -> secs_bcd saturates at 0x999.
